// File: rtl/cmd_arbiter_credit_ctrl.sv
// Shares the PSL command issue path between the restart, WED, write and read buffers and tracks PSL credits.
// Request/grant bit order: [3]=WED [2]=write [1]=read [0]=restart. Define CMD_ARBITER_STATS_EN for per-requester grant counters.
module cmd_arbiter_credit_ctrl #(
   parameter int CREDIT_BITS    = 9,
   parameter int CREDIT_RESERVE = 1,
   parameter int LINE_BITS      = 64
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enabled,
   input  logic                   credits_load,
   input  logic [7:0]             credits_init,
   input  logic                   restart_pending,
   input  logic [3:0]             request_in,
   input  logic [LINE_BITS-1:0]   restart_cmd_in,
   input  logic [LINE_BITS-1:0]   wed_cmd_in,
   input  logic [LINE_BITS-1:0]   write_cmd_in,
   input  logic [LINE_BITS-1:0]   read_cmd_in,
   input  logic                   credit_return,
   output logic [3:0]             grant_out,
   output logic [LINE_BITS-1:0]   command_out,
   output logic [CREDIT_BITS-1:0] credits_available,
   output logic                   credit_error
`ifdef CMD_ARBITER_STATS_EN
   ,
   output logic [127:0]           grant_stats_out
`endif
);

   localparam int REQ_RESTART = 0;
   localparam int REQ_READ    = 1;
   localparam int REQ_WRITE   = 2;
   localparam int REQ_WED     = 3;
   localparam int VALID_BIT   = LINE_BITS - 1;
   localparam logic [CREDIT_BITS-1:0] RESERVE = CREDIT_BITS'(CREDIT_RESERVE);
   localparam logic [CREDIT_BITS-1:0] ONE     = CREDIT_BITS'(1);

   typedef enum logic [1:0] {ARB_RESET, ARB_IDLE, ARB_RUN} arb_state_t;
   typedef enum logic {PTR_READ, PTR_WRITE} rr_ptr_t;

   arb_state_t             state_q;
   rr_ptr_t                rrPtr_q;
   logic [CREDIT_BITS-1:0] credits_q;
   logic [CREDIT_BITS-1:0] credits_d;
   logic [CREDIT_BITS-1:0] creditsMax_q;
   logic [CREDIT_BITS-1:0] loadValue;
   logic                   creditError_q;
   logic                   creditError_d;
   logic [LINE_BITS-1:0]   command_q;
   logic [LINE_BITS-1:0]   selLine;
   logic [3:0]             grant;
   logic [3:0]             eligible;
   logic                   othersOk;
   logic                   consume;
   logic                   loadAccepted;

   assign loadAccepted = credits_load && (state_q != ARB_RESET);
   assign loadValue    = {{(CREDIT_BITS-8){1'b0}}, credits_init};

   // The last CREDIT_RESERVE credits are kept for restart so a restart sequence can never be starved.
   always_comb begin
      eligible = '0;
      grant    = '0;
      selLine  = '0;
      othersOk = (credits_q > RESERVE) && !restart_pending;
      eligible[REQ_RESTART] = request_in[REQ_RESTART] && (credits_q != '0);
      eligible[REQ_READ]    = request_in[REQ_READ] && othersOk;
      eligible[REQ_WRITE]   = request_in[REQ_WRITE] && othersOk;
      eligible[REQ_WED]     = request_in[REQ_WED] && othersOk;
      if (state_q == ARB_RUN && enabled) begin
         if (eligible[REQ_RESTART]) begin
            grant[REQ_RESTART] = 1'b1;
         end else if (eligible[REQ_WED]) begin
            grant[REQ_WED] = 1'b1;
         end else if (eligible[REQ_READ] && eligible[REQ_WRITE]) begin
            if (rrPtr_q == PTR_READ) grant[REQ_READ] = 1'b1;
            else                     grant[REQ_WRITE] = 1'b1;
         end else if (eligible[REQ_READ]) begin
            grant[REQ_READ] = 1'b1;
         end else if (eligible[REQ_WRITE]) begin
            grant[REQ_WRITE] = 1'b1;
         end
      end
      if (grant[REQ_RESTART])    selLine = restart_cmd_in;
      else if (grant[REQ_WED])   selLine = wed_cmd_in;
      else if (grant[REQ_WRITE]) selLine = write_cmd_in;
      else if (grant[REQ_READ])  selLine = read_cmd_in;
   end

   // Invalid head lines are forwarded but cost no credit; a load overrides any same-cycle issue or return.
   always_comb begin
      credits_d     = credits_q;
      creditError_d = creditError_q;
      consume       = (|grant) && selLine[VALID_BIT];
      if (loadAccepted) begin
         credits_d = loadValue;
      end else if (consume && !credit_return) begin
         if (credits_q == '0) creditError_d = 1'b1;
         else                 credits_d = credits_q - ONE;
      end else if (credit_return && !consume) begin
         if (credits_q >= creditsMax_q) creditError_d = 1'b1;
         else                           credits_d = credits_q + ONE;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ARB_RESET;
         rrPtr_q       <= PTR_READ;
         credits_q     <= '0;
         creditsMax_q  <= '0;
         creditError_q <= 1'b0;
         command_q     <= '0;
      end else begin
         case (state_q)
            ARB_RESET: state_q <= ARB_IDLE;
            ARB_IDLE:  if (credits_load) state_q <= ARB_RUN;
            ARB_RUN:   if (credits_load) state_q <= ARB_IDLE;
            default:   state_q <= ARB_IDLE;
         endcase
         credits_q     <= credits_d;
         creditError_q <= creditError_d;
         if (loadAccepted) creditsMax_q <= loadValue;
         if (|grant) begin
            command_q <= selLine;
            if (grant[REQ_READ] || grant[REQ_WRITE]) begin
               rrPtr_q <= (rrPtr_q == PTR_READ) ? PTR_WRITE : PTR_READ;
            end
         end else begin
            command_q[VALID_BIT] <= 1'b0;
         end
      end
   end

   assign grant_out         = grant;
   assign command_out       = command_q;
   assign credits_available = credits_q;
   assign credit_error      = creditError_q;

`ifdef CMD_ARBITER_STATS_EN
   logic [31:0] stats_q [4];

   // Only real (valid) commands are counted, saturating at all-ones.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) stats_q[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (grant[i] && selLine[VALID_BIT] && (stats_q[i] != '1)) stats_q[i] <= stats_q[i] + 32'd1;
         end
      end
   end

   assign grant_stats_out = {stats_q[3], stats_q[2], stats_q[1], stats_q[0]};
`endif

endmodule

// File: tb/tb_cmd_arbiter_credit_ctrl.sv
// Self-checking bench for cmd_arbiter_credit_ctrl: directed vector table, hand-written corner sequences and randomized traffic against a reference model.
module tb_cmd_arbiter_credit_ctrl;

   localparam int LINE_BITS   = 64;
   localparam int CREDIT_BITS = 9;

   logic                   clock = 1'b0;
   logic                   reset;
   logic                   enabled;
   logic                   credits_load;
   logic [7:0]             credits_init;
   logic                   restart_pending;
   logic [3:0]             request_in;
   logic [LINE_BITS-1:0]   lineArr [4];
   logic                   credit_return;
   logic [3:0]             grant_out;
   logic [LINE_BITS-1:0]   command_out;
   logic [CREDIT_BITS-1:0] credits_available;
   logic                   credit_error;
`ifdef CMD_ARBITER_STATS_EN
   logic [127:0]           grant_stats_out;
`endif

   cmd_arbiter_credit_ctrl dut (
      .clock             (clock),
      .reset             (reset),
      .enabled           (enabled),
      .credits_load      (credits_load),
      .credits_init      (credits_init),
      .restart_pending   (restart_pending),
      .request_in        (request_in),
      .restart_cmd_in    (lineArr[0]),
      .wed_cmd_in        (lineArr[3]),
      .write_cmd_in      (lineArr[2]),
      .read_cmd_in       (lineArr[1]),
      .credit_return     (credit_return),
      .grant_out         (grant_out),
      .command_out       (command_out),
      .credits_available (credits_available),
      .credit_error      (credit_error)
`ifdef CMD_ARBITER_STATS_EN
      ,
      .grant_stats_out   (grant_stats_out)
`endif
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Reference model: credit pool, running flag, read/write preference and the last issued line.
   bit                 mInReset;
   bit                 mRunning;
   bit                 mPreferRead;
   bit                 mErr;
   int                 mCredits;
   int                 mMax;
   logic [LINE_BITS-1:0] mCmd;

   typedef struct {
      int         setup;
      logic [3:0] req;
      logic       rp;
      logic       en;
      logic       ret;
      logic [3:0] expGrant;
      int         expCredits;
      logic       expValid;
      logic       expErr;
      int         expSrc;
   } vec_t;

   vec_t vecs[$];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] modelGrant(input logic [3:0] req, input logic rp, input logic en);
      bit canRestart;
      bit canOther;
      if (!mRunning || !en) return 4'b0000;
      canRestart = req[0] && (mCredits > 0);
      canOther   = !rp && (mCredits > 1);
      if (canRestart)                     return 4'b0001;
      if (req[3] && canOther)             return 4'b1000;
      if (req[1] && req[2] && canOther)   return mPreferRead ? 4'b0010 : 4'b0100;
      if (req[1] && canOther)             return 4'b0010;
      if (req[2] && canOther)             return 4'b0100;
      return 4'b0000;
   endfunction

   task automatic modelReset();
      mInReset    = 1'b1;
      mRunning    = 1'b0;
      mPreferRead = 1'b1;
      mErr        = 1'b0;
      mCredits    = 0;
      mMax        = 0;
      mCmd        = '0;
   endtask

   task automatic modelStep(input logic [3:0] g, input logic load, input logic [7:0] init, input logic ret);
      logic [LINE_BITS-1:0] line;
      bit consume;
      line = '0;
      for (int i = 0; i < 4; i++) if (g[i]) line = lineArr[i];
      consume = (g != 4'b0000) && line[LINE_BITS-1];
      if (load && !mInReset) begin
         mCredits = int'(init);
         mMax     = int'(init);
         mRunning = !mRunning;
      end else if (consume && !ret) begin
         if (mCredits == 0) mErr = 1'b1;
         else               mCredits--;
      end else if (ret && !consume) begin
         if (mCredits >= mMax) mErr = 1'b1;
         else                  mCredits++;
      end
      if (g != 4'b0000) begin
         mCmd = line;
         if (g[1] || g[2]) mPreferRead = !mPreferRead;
      end else begin
         mCmd[LINE_BITS-1] = 1'b0;
      end
      mInReset = 1'b0;
   endtask

   // One clock cycle: drive at the falling edge, compare against the model, then advance the model.
   task automatic applyStimulus(input logic [3:0] req, input logic rp, input logic en, input logic ret,
                                input logic load, input logic [7:0] init, input bit rndLines);
      logic [3:0] g;
      @(negedge clock);
      if (rndLines) begin
         for (int i = 0; i < 4; i++) begin
            lineArr[i] = {1'($urandom_range(0, 9) != 0), 31'($urandom), 32'($urandom)};
         end
      end
      request_in      = req;
      restart_pending = rp;
      enabled         = en;
      credit_return   = ret;
      credits_load    = load;
      credits_init    = init;
      #1;
      g = modelGrant(req, rp, en);
      checkOutput("model grant", 64'(grant_out), 64'(g));
      checkOutput("model command", command_out, mCmd);
      checkOutput("model credits", 64'(credits_available), 64'(mCredits));
      checkOutput("model error", 64'(credit_error), 64'(mErr));
      modelStep(g, load, init, ret);
   endtask

   task automatic resetAndLoad(input int init);
      @(negedge clock);
      reset           = 1'b1;
      request_in      = '0;
      restart_pending = 1'b0;
      enabled         = 1'b1;
      credit_return   = 1'b0;
      credits_load    = 1'b0;
      credits_init    = '0;
      modelReset();
      #1;
      checkOutput("reset credits", 64'(credits_available), 64'd0);
      checkOutput("reset command", command_out, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 8'(init), 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset           = 1'b1;
      enabled         = 1'b0;
      credits_load    = 1'b0;
      credits_init    = '0;
      restart_pending = 1'b0;
      request_in      = '0;
      credit_return   = 1'b0;
      for (int i = 0; i < 4; i++) lineArr[i] = {1'b1, 63'(64'h0A0 + 64'(i) * 64'h1111)};
      modelReset();

      // setup, req, rp, en, ret, expGrant, expCredits, expValid, expErr, expSrc
      vecs.push_back('{4,  4'b0010, 1'b0, 1'b1, 1'b0, 4'b0010, 4,  1'b0, 1'b0, -1});
      vecs.push_back('{-1, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0010, 3,  1'b1, 1'b0,  1});
      vecs.push_back('{-1, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0010, 2,  1'b1, 1'b0,  1});
      vecs.push_back('{-1, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0000, 1,  1'b1, 1'b0,  1});
      vecs.push_back('{-1, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0000, 1,  1'b0, 1'b0, -1});
      vecs.push_back('{10, 4'b0110, 1'b0, 1'b1, 1'b0, 4'b0010, 10, 1'b0, 1'b0, -1});
      vecs.push_back('{-1, 4'b0110, 1'b0, 1'b1, 1'b0, 4'b0100, 9,  1'b1, 1'b0,  1});
      vecs.push_back('{-1, 4'b0110, 1'b0, 1'b1, 1'b0, 4'b0010, 8,  1'b1, 1'b0,  2});
      vecs.push_back('{-1, 4'b0110, 1'b0, 1'b1, 1'b0, 4'b0100, 7,  1'b1, 1'b0,  1});
      vecs.push_back('{-1, 4'b0100, 1'b0, 1'b1, 1'b0, 4'b0100, 6,  1'b1, 1'b0,  2});
      vecs.push_back('{-1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 5,  1'b1, 1'b0,  2});
      vecs.push_back('{1,  4'b0011, 1'b0, 1'b1, 1'b0, 4'b0001, 1,  1'b0, 1'b0, -1});
      vecs.push_back('{-1, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0000, 0,  1'b1, 1'b0,  0});
      vecs.push_back('{-1, 4'b0010, 1'b0, 1'b1, 1'b1, 4'b0000, 0,  1'b0, 1'b0, -1});
      vecs.push_back('{-1, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0000, 1,  1'b0, 1'b0, -1});
      vecs.push_back('{5,  4'b0010, 1'b0, 1'b1, 1'b1, 4'b0010, 5,  1'b0, 1'b0, -1});
      vecs.push_back('{-1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 5,  1'b1, 1'b0,  1});
      vecs.push_back('{8,  4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 8,  1'b0, 1'b0, -1});
      vecs.push_back('{-1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 8,  1'b0, 1'b1, -1});
      vecs.push_back('{-1, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0010, 8,  1'b0, 1'b1, -1});
      vecs.push_back('{-1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 7,  1'b1, 1'b1,  1});
      vecs.push_back('{10, 4'b0110, 1'b1, 1'b1, 1'b0, 4'b0000, 10, 1'b0, 1'b0, -1});
      vecs.push_back('{-1, 4'b0111, 1'b1, 1'b1, 1'b0, 4'b0001, 10, 1'b0, 1'b0, -1});
      vecs.push_back('{-1, 4'b1110, 1'b0, 1'b1, 1'b0, 4'b1000, 9,  1'b1, 1'b0,  0});
      vecs.push_back('{-1, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0010, 8,  1'b1, 1'b0,  3});
      vecs.push_back('{-1, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 7,  1'b1, 1'b0,  1});
      vecs.push_back('{-1, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 7,  1'b0, 1'b0, -1});

      foreach (vecs[k]) begin
         if (vecs[k].setup >= 0) resetAndLoad(vecs[k].setup);
         applyStimulus(vecs[k].req, vecs[k].rp, vecs[k].en, vecs[k].ret, 1'b0, 8'd0, 1'b0);
         checkOutput($sformatf("vec%0d grant", k), 64'(grant_out), 64'(vecs[k].expGrant));
         checkOutput($sformatf("vec%0d credits", k), 64'(credits_available), 64'(vecs[k].expCredits));
         checkOutput($sformatf("vec%0d valid", k), 64'(command_out[LINE_BITS-1]), 64'(vecs[k].expValid));
         checkOutput($sformatf("vec%0d error", k), 64'(credit_error), 64'(vecs[k].expErr));
         if (vecs[k].expSrc >= 0) begin
            checkOutput($sformatf("vec%0d payload", k), command_out, lineArr[vecs[k].expSrc]);
         end
      end

      // Invalid head line: granted and forwarded, but the credit count is untouched.
      resetAndLoad(5);
      lineArr[1][LINE_BITS-1] = 1'b0;
      applyStimulus(4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      checkOutput("invalid line grant", 64'(grant_out), 64'b0010);
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      checkOutput("invalid line forwarded", command_out, lineArr[1]);
      checkOutput("invalid line credits", 64'(credits_available), 64'd5);
      lineArr[1][LINE_BITS-1] = 1'b1;

      // Reset in the middle of a read burst clears everything at once and grants stop until a reload.
      resetAndLoad(3);
      applyStimulus(4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      @(posedge clock);
      #2;
      checkOutput("burst valid", 64'(command_out[LINE_BITS-1]), 64'd1);
      checkOutput("burst credits", 64'(credits_available), 64'd2);
      reset = 1'b1;
      #1;
      checkOutput("async reset grant", 64'(grant_out), 64'd0);
      checkOutput("async reset valid", 64'(command_out[LINE_BITS-1]), 64'd0);
      checkOutput("async reset credits", 64'(credits_available), 64'd0);
      modelReset();
      #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
         checkOutput("no grant after reset", 64'(grant_out), 64'd0);
      end

      // Randomized traffic against the reference model.
      resetAndLoad(int'($urandom_range(2, 20)));
      for (int c = 0; c < 600; c++) begin
         logic ld;
         ld = 1'($urandom_range(0, 49) == 0);
         applyStimulus(4'($urandom), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) != 0),
                       1'($urandom_range(0, 3) == 0), ld, 8'($urandom_range(1, 30)), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
